// File: rtl/mode_counter.sv
// mode_counter: four-sequence counter (binary up/down, Gray, Johnson)
// with synchronous load, restart on mode change and wrap/tc flags.
module mode_counter #(
   parameter int WIDTH = 4,
   parameter int MOD   = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [1:0] M_UP   = 2'b00;
   localparam logic [1:0] M_DOWN = 2'b01;
   localparam logic [1:0] M_GRAY = 2'b10;
   localparam logic [1:0] M_JOHN = 2'b11;

   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] LASTV = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] JLAST = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH:0]   MODX  = (WIDTH+1)'(MOD);
   localparam logic [WIDTH-2:0] TONE  = (WIDTH-1)'(1);

   logic [1:0]       mode_r;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] b_inc;
   logic [WIDTH-1:0] adv_q;
   logic [WIDTH-1:0] adv_b;
   logic [WIDTH-1:0] ld_q;
   logic [WIDTH-1:0] ld_b;
   logic [WIDTH-2:0] jt;
   logic             j_bad;
   logic             last;
   logic             over;

   function automatic logic [WIDTH-1:0] gray(input logic [WIDTH-1:0] x);
      return x ^ (x >> 1);
   endfunction

   // A legal Johnson code has at most one differing adjacent bit pair
   assign jt    = q[WIDTH-2:0] ^ q[WIDTH-1:1];
   assign j_bad = |(jt & (jt - TONE));
   assign b_inc = b + ONE;
   assign over  = {1'b0, din} >= MODX;

   always_comb begin
      last  = 1'b0;
      adv_q = q;
      adv_b = b;
      case (mode_r)
         M_UP: begin
            last  = (q == LASTV);
            adv_q = last ? '0 : q + ONE;
         end
         M_DOWN: begin
            last  = (q == '0);
            adv_q = last ? LASTV : q - ONE;
         end
         M_GRAY: begin
            last  = &b;
            adv_b = b_inc;
            adv_q = gray(b_inc);
         end
         default: begin
            last  = (q == JLAST);
            adv_q = j_bad ? '0 : {q[WIDTH-2:0], ~q[WIDTH-1]};
         end
      endcase
   end

   always_comb begin
      ld_b = b;
      case (mode)
         M_UP, M_DOWN: ld_q = over ? '0 : din;
         M_GRAY: begin
            ld_q = gray(din);
            ld_b = din;
         end
         M_JOHN:  ld_q = din;
         default: ld_q = din;
      endcase
   end

   assign tc = en & last;

   always_ff @(posedge clk) begin
      mode_r <= mode;
      if (!clr) begin
         q    <= '0;
         b    <= '0;
         wrap <= 1'b0;
      end else if (load) begin
         q    <= ld_q;
         b    <= ld_b;
         wrap <= 1'b0;
      end else if (mode != mode_r) begin
         q    <= '0;
         b    <= '0;
         wrap <= 1'b0;
      end else if (en) begin
         q    <= adv_q;
         b    <= adv_b;
         wrap <= last;
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and data width; legal range is 2 to 16.
REQ-002 Parameter MOD, default 16, modulus for the binary up and down modes; legal range is 2 to 2**WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 clr  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  count enable; when low, the counter SHALL hold its state.
REQ-006 load  input  1  synchronous parallel load strobe.
REQ-007 din  input  WIDTH  load value.
REQ-008 mode  input  2  sequence select: 00 binary up, 01 binary down, 10 Gray up, 11 Johnson.
REQ-009 q  output  WIDTH  registered counter code.
REQ-010 tc  output  1  combinational terminal count; SHALL equal en AND (q is the last state of the current sequence).
REQ-011 wrap  output  1  registered one-cycle pulse, high on the cycle after the sequence wrapped.

Function
REQ-012 Priority at each edge SHALL be: clr low, then load, then mode change, then en, then hold.
REQ-013 The mode input SHALL be registered every cycle into mode_r.
REQ-014 Mode change is defined as mode differing from mode_r with load low; on a mode change, q, the internal index b and wrap SHALL clear to 0 regardless of en.
REQ-015 Binary up (00): q SHALL advance q+1, and q==MOD-1 SHALL advance to 0; the last state is MOD-1.
REQ-016 Binary down (01): q SHALL advance q-1, and q==0 SHALL advance to MOD-1; the last state is 0.
REQ-017 Gray (10): an internal WIDTH-bit binary index b SHALL increment modulo 2**WIDTH, and q SHALL be registered as b^(b>>1); the last state is b all-ones.
REQ-018 Johnson (11): q SHALL advance to {q[WIDTH-2:0], ~q[WIDTH-1]}, giving a period of 2*WIDTH; the last state is MSB-only set (100..0).
REQ-019 Johnson illegal code: a code is illegal when more than one adjacent bit pair differs; an illegal q SHALL go to 0 on the next enabled edge instead of shifting.
REQ-020 Load, binary modes: q SHALL take din; if din>=MOD, q SHALL take 0.
REQ-021 Load, Gray mode: b SHALL take din and q SHALL take gray(din).
REQ-022 Load, Johnson mode: q SHALL take din unchanged; any illegal code is corrected per REQ-019.
REQ-023 Load SHALL clear wrap and SHALL NOT require en.
REQ-024 wrap SHALL be set at the edge where an enabled advance leaves the last state, and SHALL clear at every other edge.
REQ-025 Count latency SHALL be one cycle: q reflects an enabled edge immediately after that edge.
REQ-026 No combinational path SHALL exist from din or mode to q; tc SHALL depend only on en, q, b and mode_r.
REQ-027 Arithmetic SHALL be WIDTH bits wide, with no overflow beyond the MOD wrap defined in REQ-015 and REQ-016.

Reset
REQ-028 While clr is low at an edge, q, b and wrap SHALL become 0 and mode_r SHALL take mode, so that no spurious mode-change restart follows reset.
REQ-029 Reset SHALL take precedence over load, en and mode change mid-operation.
REQ-030 Reset SHALL NOT be asynchronous; a clr pulse between clock edges SHALL have no effect.

Verification (WIDTH=4, MOD=10)
REQ-031 Binary up: reset, mode=00, en=1 for 12 edges -> q=0..9,0,1; tc high while q=9; wrap high for one cycle with q=0.
REQ-032 Binary down: reset, mode=01, en=1 -> q=0,9,8,...,1,0,9; tc high while q=0; wrap high for one cycle after each 0->9 transition.
REQ-033 Gray: reset, mode=10, en=1 for 16 edges -> q=0000,0001,0011,0010,0110,... ending 1000, then 0000; tc high at q=1000.
REQ-034 Johnson: mode=11 -> q=0000,0001,0011,0111,1111,1110,1100,1000,0000 with tc at 1000; then load din=0101 -> q=0101; one enabled edge -> q=0000.
REQ-035 Load and mode change, mode=00: load din=12 -> q=0; load din=7 with en=1 -> q=7; at q=5, switch mode to 01 with en=1 -> q=0 on the next edge, then counting down 9,8.
REQ-036 Reset priority: mid-count at q=6 in mode 00, clr=0 with load=1, din=3, en=1 -> q=0 and wrap=0 after the edge; a clr glitch between edges -> q unaffected.
